// File: rtl/adc_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Package  : adc_pkt_pkg
// Summary  : shared state encoding, header layout and header builder for the
//            ADC AXI-Stream packetizer.
// Revision : 1.0 - initial release
// ============================================================================
package adc_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } pkt_state_e;

  localparam int unsigned c_beat_w   = 64;
  localparam int unsigned c_magic_lsb = 48;
  localparam int unsigned c_magic_w   = 16;
  localparam int unsigned c_seq_lsb   = 16;
  localparam int unsigned c_seq_w     = 32;
  localparam int unsigned c_len_lsb   = 0;
  localparam int unsigned c_len_w     = 16;

  localparam logic [15:0] c_hdr_magic_default = 16'hADC0;

  function automatic logic [c_beat_w-1:0] build_hdr(
    input logic [c_magic_w-1:0] magic,
    input logic [c_seq_w-1:0]   seq,
    input logic [c_len_w-1:0]   len
  );
    logic [c_beat_w-1:0] hdr;
    hdr = '0;
    hdr[c_magic_lsb +: c_magic_w] = magic;
    hdr[c_seq_lsb   +: c_seq_w]   = seq;
    hdr[c_len_lsb   +: c_len_w]   = len;
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_pkt_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkt_out_reg
// Summary  : registered AXI-Stream output stage; reloads whenever the held
//            beat is empty or being taken downstream.
// Revision : 1.0 - initial release
// ============================================================================
module adc_pkt_out_reg #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_user,
  input  logic              i_ready,
  output logic              o_load_en,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_user
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              user_q, user_d;

  assign o_load_en = !valid_q || i_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    if (o_load_en) begin
      valid_d = i_wr;
      last_d  = i_wr && i_last;
      user_d  = i_wr && i_user;
      // data is left untouched on an empty load to avoid needless toggling
      if (i_wr) begin
        data_d = i_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_last  = last_q;
  assign o_user  = user_q;

endmodule
`default_nettype wire

// File: rtl/adc_axis_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : adc_axis_packetizer
// Summary  : frames 64-bit ADC beats into header + payload AXI-Stream packets.
//            Define ADC_PKT_GAP_CHECK_EN to build the sample-counter gap check.
// Revision : 1.0 - initial release
// ============================================================================
module adc_axis_packetizer
  import adc_pkt_pkg::*;
#(
  parameter int unsigned ADC_AXI_DATA_WIDTH = 64,
  parameter int unsigned PKT_BEATS          = 128,
  parameter logic [15:0] HDR_MAGIC          = c_hdr_magic_default
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          enable,
  input  logic [ADC_AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [ADC_AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [7:0]                    m_axis_tkeep,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic [31:0]                   pkt_seq,
  output logic [15:0]                   gap_count
);

  localparam logic [15:0] c_pkt_len   = 16'(PKT_BEATS);
  localparam logic [15:0] c_last_beat = 16'(PKT_BEATS - 1);

  pkt_state_e state_q, state_d;
  logic [15:0] beat_cnt_q, beat_cnt_d;
  logic [31:0] pkt_seq_q, pkt_seq_d;
  logic        hdr_loaded_q, hdr_loaded_d;

  logic                          w_load_en;
  logic                          w_out_wr;
  logic [ADC_AXI_DATA_WIDTH-1:0] w_out_data;
  logic                          w_out_last;
  logic                          w_out_user;
  logic                          w_beat_last;
  logic                          w_s_accept;
  logic                          w_hdr_accept;
  logic [c_beat_w-1:0]           w_hdr;

  assign w_hdr        = build_hdr(HDR_MAGIC, pkt_seq_q, c_pkt_len);
  assign w_beat_last  = (beat_cnt_q == c_last_beat) || s_axis_tlast;
  assign w_s_accept   = (state_q == ST_PAYLOAD) && s_axis_tvalid && w_load_en;
  // hdr_loaded_q guards against mistaking the previous packet's tlast beat for the header
  assign w_hdr_accept = (state_q == ST_HDR) && hdr_loaded_q && m_axis_tvalid && m_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && s_axis_tvalid && w_load_en) begin
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_hdr_accept) begin
          state_d = ST_PAYLOAD;
        end else if (!hdr_loaded_q && !enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (w_s_accept && w_beat_last) begin
          state_d = (enable && s_axis_tvalid) ? ST_HDR : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b0;
    w_out_wr      = 1'b0;
    w_out_data    = w_hdr;
    w_out_last    = 1'b0;
    w_out_user    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_out_wr = enable && s_axis_tvalid;
      end
      ST_HDR: begin
        // a header is only built once a sample is waiting, so no empty packets
        w_out_wr = !hdr_loaded_q && enable && s_axis_tvalid;
      end
      ST_PAYLOAD: begin
        s_axis_tready = w_load_en;
        w_out_wr      = s_axis_tvalid;
        w_out_data    = s_axis_tdata;
        w_out_last    = w_beat_last;
        w_out_user    = s_axis_tlast && (beat_cnt_q != c_last_beat);
      end
      default: ;
    endcase
  end

  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    pkt_seq_d    = pkt_seq_q;
    hdr_loaded_d = hdr_loaded_q;
    if (w_s_accept) begin
      beat_cnt_d = w_beat_last ? 16'd0 : beat_cnt_q + 16'd1;
    end
    if ((state_q != ST_PAYLOAD) && w_out_wr && w_load_en) begin
      hdr_loaded_d = 1'b1;
    end
    if (w_hdr_accept) begin
      hdr_loaded_d = 1'b0;
      pkt_seq_d    = pkt_seq_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_cnt_q   <= '0;
      pkt_seq_q    <= '0;
      hdr_loaded_q <= 1'b0;
    end else begin
      beat_cnt_q   <= beat_cnt_d;
      pkt_seq_q    <= pkt_seq_d;
      hdr_loaded_q <= hdr_loaded_d;
    end
  end

  adc_pkt_out_reg #(
    .DATA_W (ADC_AXI_DATA_WIDTH)
  ) u_out_reg (
    .clk       (aclk),
    .rst       (areset),
    .i_wr      (w_out_wr),
    .i_data    (w_out_data),
    .i_last    (w_out_last),
    .i_user    (w_out_user),
    .i_ready   (m_axis_tready),
    .o_load_en (w_load_en),
    .o_data    (m_axis_tdata),
    .o_valid   (m_axis_tvalid),
    .o_last    (m_axis_tlast),
    .o_user    (m_axis_tuser)
  );

  assign m_axis_tkeep = 8'hFF;
  assign pkt_seq      = pkt_seq_q;

`ifdef ADC_PKT_GAP_CHECK_EN
  logic [31:0] prev_cnt_q, prev_cnt_d;
  logic        have_prev_q, have_prev_d;
  logic [15:0] gap_q, gap_d;
  logic [31:0] w_cur_cnt;

  assign w_cur_cnt = s_axis_tdata[63:32];

  // continuity is checked across packet boundaries, but restarts after a capture end
  always_comb begin
    prev_cnt_d  = prev_cnt_q;
    have_prev_d = have_prev_q;
    gap_d       = gap_q;
    if (w_s_accept) begin
      if (have_prev_q && (w_cur_cnt != prev_cnt_q + 32'd1) && (gap_q != 16'hFFFF)) begin
        gap_d = gap_q + 16'd1;
      end
      prev_cnt_d  = w_cur_cnt;
      have_prev_d = !s_axis_tlast;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      prev_cnt_q  <= '0;
      have_prev_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      prev_cnt_q  <= prev_cnt_d;
      have_prev_q <= have_prev_d;
      gap_q       <= gap_d;
    end
  end

  assign gap_count = gap_q;
`else
  assign gap_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_axis_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_axis_packetizer
// Summary  : self-checking bench for adc_axis_packetizer (PKT_BEATS=4) with a
//            packet-level reference model; honours ADC_PKT_GAP_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_axis_packetizer;

  localparam int unsigned PKT   = 4;
  localparam logic [15:0] MAGIC = 16'hADC0;
`ifdef ADC_PKT_GAP_CHECK_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset, enable;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tlast, s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid, m_tlast, m_tuser, m_tready;
  logic [7:0]  m_tkeep;
  logic [31:0] pkt_seq;
  logic [15:0] gap_count;

  adc_axis_packetizer #(
    .ADC_AXI_DATA_WIDTH (64),
    .PKT_BEATS          (PKT),
    .HDR_MAGIC          (MAGIC)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .pkt_seq       (pkt_seq),
    .gap_count     (gap_count)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  int checks = 0;
  int errors = 0;

  beat_t       src_q[$];
  beat_t       inq[$];
  int          out_pos, pkts_seen, shorts_seen, scen_acc, gap_m;
  logic [31:0] seq_m, prev_m, ctr;
  bit          have_prev_m, acc_prev, stall_prev, lat_pending, lat_arm, rand_en;
  logic [63:0] prev_data;
  logic        prev_last, prev_user;
  int          rdy_mode, valid_pct, drop_at;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    src_q.delete();
    inq.delete();
    out_pos = 0; seq_m = 0; gap_m = 0; have_prev_m = 0; prev_m = 0;
    acc_prev = 0; stall_prev = 0; lat_arm = 0;
  endtask

  task automatic push_beats(input int n, input int last_idx, input int jump_pct);
    for (int i = 0; i < n; i++) begin
      src_q.push_back({ctr, 32'($urandom), (i == last_idx)});
      if ($urandom_range(99) < jump_pct) ctr = ctr + 32'($urandom_range(1000, 2));
      else ctr = ctr + 32'd1;
    end
  endtask

  task automatic cycle();
    beat_t       b;
    int          pos;
    logic        el, eu;
    logic [31:0] cur;
    @(negedge aclk);
    if (acc_prev) begin s_tvalid = 1'b0; acc_prev = 0; end
    if (drop_at >= 0 && scen_acc >= drop_at) enable = 1'b0;
    if (rand_en) enable = ($urandom_range(99) < 85);
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(99) < 60);
    endcase
    if (!s_tvalid && src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      s_tdata  = src_q[0].data;
      s_tlast  = src_q[0].last;
      s_tvalid = 1'b1;
    end
    #1;
    if (lat_arm) begin
      chk("hdr_latency", 64'(m_tvalid), 64'd1);
      lat_arm = 0;
    end
    if (lat_pending && s_tvalid && enable) begin lat_pending = 0; lat_arm = 1; end
    if (stall_prev) begin
      chk("stall_valid", 64'(m_tvalid), 64'd1);
      chk("stall_data", m_tdata, prev_data);
      chk("stall_last_user", 64'({m_tlast, m_tuser}), 64'({prev_last, prev_user}));
    end
    stall_prev = m_tvalid && !m_tready;
    prev_data = m_tdata; prev_last = m_tlast; prev_user = m_tuser;
    chk("pkt_seq", 64'(pkt_seq), 64'(seq_m));
    chk("gap_count", 64'(gap_count), GAP_EN ? 64'(gap_m) : 64'd0);
    if (m_tvalid && m_tready) begin
      chk("tkeep", 64'(m_tkeep), 64'hFF);
      if (out_pos == 0) begin
        chk("hdr_data", m_tdata, {MAGIC, seq_m, 16'(PKT)});
        chk("hdr_last_user", 64'({m_tlast, m_tuser}), 64'd0);
        seq_m = seq_m + 32'd1;
        out_pos = 1;
      end else begin
        checks++;
        assert (inq.size() > 0) else begin
          errors++;
          $error("FAIL payload_source: observed payload %0h expected no beat pending", m_tdata);
        end
        if (inq.size() > 0) begin
          b   = inq.pop_front();
          pos = out_pos - 1;
          el  = (pos == PKT - 1) || b.last;
          eu  = b.last && (pos != PKT - 1);
          chk("pay_data", m_tdata, b.data);
          chk("pay_last_user", 64'({m_tlast, m_tuser}), 64'({el, eu}));
          if (el) begin
            out_pos = 0;
            pkts_seen++;
            if (eu) shorts_seen++;
          end else begin
            out_pos++;
          end
        end
      end
    end
    if (s_tvalid && s_tready) begin
      cur = s_tdata[63:32];
      if (have_prev_m && cur != prev_m + 32'd1 && gap_m < 65535) gap_m++;
      prev_m = cur;
      have_prev_m = !s_tlast;
      inq.push_back({s_tdata, s_tlast});
      void'(src_q.pop_front());
      scen_acc++;
      acc_prev = 1;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (n < budget && !(src_q.size() == 0 && inq.size() == 0 && out_pos == 0 && !m_tvalid)) begin
      cycle();
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  initial begin
    int p0, s0, n;
    areset = 1'b1; enable = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    rdy_mode = 0; valid_pct = 100; drop_at = -1; rand_en = 0; ctr = 0;
    pkts_seen = 0; shorts_seen = 0; scen_acc = 0; lat_pending = 0;
    model_reset();
    repeat (2) @(negedge aclk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tuser", 64'(m_tuser), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_pkt_seq", 64'(pkt_seq), 64'd0);
    chk("rst_gap_count", 64'(gap_count), 64'd0);
    areset = 1'b0;
    enable = 1'b1;

    // A: two full packets, counters 0..7, tready high
    lat_pending = 1;
    p0 = pkts_seen;
    push_beats(8, -1, 0);
    drain("A_drain", 200);
    chk("A_pkts", 64'(pkts_seen - p0), 64'd2);
    chk("A_seq", 64'(pkt_seq), 64'd2);

    // B: capture ends on the 3rd beat, then a full packet
    p0 = pkts_seen; s0 = shorts_seen;
    push_beats(3, 2, 0);
    push_beats(4, -1, 0);
    drain("B_drain", 200);
    chk("B_pkts", 64'(pkts_seen - p0), 64'd2);
    chk("B_shorts", 64'(shorts_seen - s0), 64'd1);
    chk("B_seq", 64'(pkt_seq), 64'd4);

    // C: downstream ready toggling every cycle
    rdy_mode = 1;
    p0 = pkts_seen;
    push_beats(8, -1, 0);
    drain("C_drain", 300);
    chk("C_pkts", 64'(pkts_seen - p0), 64'd2);

    // D: enable dropped after the first payload beat
    rdy_mode = 0; scen_acc = 0; drop_at = 1;
    p0 = pkts_seen;
    push_beats(6, -1, 0);
    n = 0;
    while (pkts_seen < p0 + 1 && n < 100) begin cycle(); n++; end
    chk("D_complete", 64'(n < 100), 64'd1);
    repeat (10) begin
      cycle();
      chk("D_s_tready_idle", 64'(s_tready), 64'd0);
      chk("D_m_tvalid_idle", 64'(m_tvalid), 64'd0);
    end
    chk("D_beats", 64'(scen_acc), 64'd4);
    drop_at = -1; enable = 1'b1;

    // E: random valid, ready, enable, capture ends and counter jumps
    rdy_mode = 2; valid_pct = 70; rand_en = 1;
    push_beats(2, 1, 0);
    for (int k = 0; k < 150; k++) begin
      push_beats(1, ($urandom_range(99) < 6) ? 0 : -1, 10);
    end
    repeat (400) cycle();
    rand_en = 0; enable = 1'b1;
    push_beats(1, 0, 0);
    drain("E_drain", 3000);

    // F: asynchronous reset in the middle of a payload
    rdy_mode = 0; valid_pct = 100; scen_acc = 0;
    push_beats(6, -1, 0);
    n = 0;
    while (scen_acc < 2 && n < 50) begin cycle(); n++; end
    chk("F_reached", 64'(n < 50), 64'd1);
    #1 areset = 1'b1;
    #1;
    chk("F_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("F_m_tlast", 64'(m_tlast), 64'd0);
    chk("F_m_tuser", 64'(m_tuser), 64'd0);
    chk("F_m_tdata", m_tdata, 64'd0);
    chk("F_s_tready", 64'(s_tready), 64'd0);
    chk("F_pkt_seq", 64'(pkt_seq), 64'd0);
    chk("F_gap_count", 64'(gap_count), 64'd0);
    s_tvalid = 1'b0; s_tlast = 1'b0;
    model_reset();
    repeat (2) @(negedge aclk);
    #1 areset = 1'b0;

    // G: counters 10, 11, 13, 14 form exactly one discontinuity
    src_q.push_back({32'd10, 32'($urandom), 1'b0});
    src_q.push_back({32'd11, 32'($urandom), 1'b0});
    src_q.push_back({32'd13, 32'($urandom), 1'b0});
    src_q.push_back({32'd14, 32'($urandom), 1'b1});
    drain("G_drain", 200);
    cycle();
    chk("G_gap_directed", 64'(gap_count), GAP_EN ? 64'd1 : 64'd0);
    chk("G_seq", 64'(pkt_seq), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
